// File: rtl/run_sequencer.sv
// run_sequencer
//
// Host-side run controller placed in front of the CPU top level. It accepts a
// run request carrying a program index and then drives the CPU's reset and
// start inputs. Next it counts execution cycles until the CPU raises its done
// flag. At the end it reports the cycle count, a timeout flag or a request
// error to the host.
//
// Ports
//   Clk         clock, rising edge only
//   Reset       asynchronous, active-high reset
//   Go          run request; sampled only while idle
//   ProgSel     requested program index; sampled together with Go
//   CpuAck      CPU done flag; looked at only while the CPU is running
//   CpuReset    drives the CPU reset input
//   CpuStart    drives the CPU start input; a single-cycle pulse
//   ProgIdx     program index latched at the last accepted request
//   Busy        high while the CPU is being reset, started or is running
//   Done        one-cycle completion pulse
//   TimedOut    the last run reached MAX_CYCLES without an ack
//   Error       the last request carried an out-of-range program index
//   CycleCount  number of RUN cycles with CpuAck low in the last/current run
//
// Every output comes straight from a flop. The output process computes each
// output's value for the next cycle, using the next state.

module run_sequencer #(
  parameter int NUM_PROGS  = 3,
  parameter int PROG_W     = 2,
  parameter int CYC_W      = 16,
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 16'hFFFF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Go,
  input  logic [PROG_W-1:0] ProgSel,
  input  logic              CpuAck,
  output logic              CpuReset,
  output logic              CpuStart,
  output logic [PROG_W-1:0] ProgIdx,
  output logic              Busy,
  output logic              Done,
  output logic              TimedOut,
  output logic              Error,
  output logic [CYC_W-1:0]  CycleCount
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0]   RST_LAST   = RC_W'(RST_CYCLES - 1);
  localparam logic [CYC_W-1:0]  CYC_MAX    = CYC_W'(MAX_CYCLES);
  localparam logic [PROG_W:0]   PROG_LIMIT = (PROG_W + 1)'(NUM_PROGS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_START,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;

  logic              cpu_reset_d, cpu_start_d, busy_d, done_d, timed_out_d, error_d;
  logic [PROG_W-1:0] prog_idx_d;
  logic [CYC_W-1:0]  cycle_count_d;

  // The extra leading bit keeps the range check correct even when NUM_PROGS
  // equals 2**PROG_W.
  logic             accept, prog_ok, run_tick, hit_max;
  logic [CYC_W-1:0] cyc_inc;

  assign accept   = (state_q == S_IDLE) && Go;
  assign prog_ok  = {1'b0, ProgSel} < PROG_LIMIT;
  assign run_tick = (state_q == S_RUN) && !CpuAck;
  assign cyc_inc  = CycleCount + CYC_W'(1);
  // The next count is compared so that the run ends on the cycle in which the
  // count reaches MAX_CYCLES. As a result the counter never wraps.
  assign hit_max  = (cyc_inc == CYC_MAX);

  // State register, together with all registered outputs.
  // NOTE: every flop here holds control state or a host-visible output, so
  // all of them take a defined value on reset; the FSM has no storage arrays.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      rst_cnt_q  <= '0;
      CpuReset   <= 1'b1;
      CpuStart   <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      TimedOut   <= 1'b0;
      Error      <= 1'b0;
      ProgIdx    <= '0;
      CycleCount <= '0;
    end else begin
      // NOTE: non-blocking assignments, so that every flop samples the
      // pre-edge values no matter what order these lines appear in.
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      CpuReset   <= cpu_reset_d;
      CpuStart   <= cpu_start_d;
      Busy       <= busy_d;
      Done       <= done_d;
      TimedOut   <= timed_out_d;
      Error      <= error_d;
      ProgIdx    <= prog_idx_d;
      CycleCount <= cycle_count_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaults come first, so every path assigns every signal and no
    // latches are inferred.
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (Go) begin
          if (prog_ok) begin
            state_d   = S_RST;
            rst_cnt_d = RST_LAST;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RST: begin
        if (rst_cnt_q == '0) state_d   = S_START;
        else                 rst_cnt_d = rst_cnt_q - RC_W'(1);
      end
      S_START: state_d = S_RUN;
      S_RUN: begin
        if (CpuAck || hit_max) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: the value each output flop takes at the next edge.
  always_comb begin
    cpu_reset_d   = (state_d == S_RST);
    cpu_start_d   = (state_d == S_START);
    busy_d        = (state_d == S_RST) || (state_d == S_START) || (state_d == S_RUN);
    done_d        = (state_d == S_DONE);
    prog_idx_d    = ProgIdx;
    cycle_count_d = CycleCount;
    timed_out_d   = TimedOut;
    error_d       = Error;
    if (accept) begin
      prog_idx_d    = ProgSel;
      cycle_count_d = '0;
      timed_out_d   = 1'b0;
      error_d       = !prog_ok;
    end else if (run_tick) begin
      cycle_count_d = cyc_inc;
      if (hit_max) timed_out_d = 1'b1;
    end
  end

endmodule
